// File: rtl/blowfish_round_ctrl.sv
// Iterative Blowfish block-encrypt sequencer: owns L/R state, round counter and table
// addressing for one shared Feistel round datapath; P and S storage live outside.
module blowfish_round_ctrl #(
    parameter int ROUNDS  = 16,
    parameter int PADDR_W = 5
) (
    input  logic               clk,
    input  logic               reset_l,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [31:0]        in_l,
    input  logic [31:0]        in_r,
    output logic [PADDR_W-1:0] p_addr,
    input  logic [31:0]        p_data,
    output logic [7:0]         s_addr0,
    output logic [7:0]         s_addr1,
    output logic [7:0]         s_addr2,
    output logic [7:0]         s_addr3,
    input  logic [31:0]        s_data0,
    input  logic [31:0]        s_data1,
    input  logic [31:0]        s_data2,
    input  logic [31:0]        s_data3,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [31:0]        out_l,
    output logic [31:0]        out_r,
    output logic               busy
);

    localparam int IDX_W = (ROUNDS > 2) ? $clog2(ROUNDS) : 1;
    localparam logic [IDX_W-1:0]   LAST_IDX = IDX_W'(ROUNDS - 1);
    localparam logic [PADDR_W-1:0] P_FIN_A  = PADDR_W'(ROUNDS);
    localparam logic [PADDR_W-1:0] P_FIN_B  = PADDR_W'(ROUNDS + 1);

    typedef enum logic [2:0] {IDLE, RND_A, RND_B, FIN_A, FIN_B, DONE} state_t;

    state_t           state_q, state_d;
    logic [31:0]      l_q, l_d, r_q, r_d;
    logic [IDX_W-1:0] idx_q, idx_d;
    logic [31:0]      out_l_q, out_l_d, out_r_q, out_r_d;
    logic             out_valid_q, out_valid_d;
    logic [31:0]      t;

    function automatic logic [31:0] feistel_f(input logic [31:0] a, input logic [31:0] b,
                                              input logic [31:0] c, input logic [31:0] d);
        return ((a + b) ^ c) + d;
    endfunction

    // P address depends only on registered state so the external combinational read cannot loop back.
    always_comb begin
        p_addr = '0;
        case (state_q)
            RND_A:   p_addr = PADDR_W'(idx_q);
            FIN_A:   p_addr = P_FIN_A;
            FIN_B:   p_addr = P_FIN_B;
            default: p_addr = '0;
        endcase
    end

    always_comb begin
        t = l_q ^ p_data;
        {s_addr0, s_addr1, s_addr2, s_addr3} = '0;
        if (state_q == RND_A) begin
            {s_addr0, s_addr1, s_addr2, s_addr3} = t;
        end
    end

    always_comb begin
        state_d     = state_q;
        l_d         = l_q;
        r_d         = r_q;
        idx_d       = idx_q;
        out_l_d     = out_l_q;
        out_r_d     = out_r_q;
        out_valid_d = out_valid_q;
        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    l_d     = in_l;
                    r_d     = in_r;
                    idx_d   = '0;
                    state_d = RND_A;
                end
            end
            RND_A: begin
                l_d     = l_q ^ p_data;
                state_d = RND_B;
            end
            RND_B: begin
                l_d = r_q ^ feistel_f(s_data0, s_data1, s_data2, s_data3);
                r_d = l_q;
                if (idx_q == LAST_IDX) begin
                    state_d = FIN_A;
                end else begin
                    idx_d   = idx_q + 1'b1;
                    state_d = RND_A;
                end
            end
            // The final round's swap is undone here by crossing L and R.
            FIN_A: begin
                r_d     = l_q ^ p_data;
                l_d     = r_q;
                state_d = FIN_B;
            end
            FIN_B: begin
                l_d         = l_q ^ p_data;
                out_l_d     = l_q ^ p_data;
                out_r_d     = r_q;
                out_valid_d = 1'b1;
                state_d     = DONE;
            end
            DONE: begin
                if (out_ready) begin
                    out_valid_d = 1'b0;
                    state_d     = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_l) begin
        if (!reset_l) begin
            state_q     <= IDLE;
            l_q         <= '0;
            r_q         <= '0;
            idx_q       <= '0;
            out_l_q     <= '0;
            out_r_q     <= '0;
            out_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            l_q         <= l_d;
            r_q         <= r_d;
            idx_q       <= idx_d;
            out_l_q     <= out_l_d;
            out_r_q     <= out_r_d;
            out_valid_q <= out_valid_d;
        end
    end

    assign in_ready  = (state_q == IDLE);
    assign busy      = (state_q != IDLE);
    assign out_valid = out_valid_q;
    assign out_l     = out_l_q;
    assign out_r     = out_r_q;

endmodule

// File: tb/tb_blowfish_round_ctrl.sv
// Bench for blowfish_round_ctrl: external P/S tables, reference Blowfish encryption,
// per-cycle addressing checks, output hold, mid-block reset and back-to-back blocks.
module tb_blowfish_round_ctrl;

    localparam int ROUNDS = 16;

    logic        clk = 1'b0;
    logic        reset_l;
    logic        in_valid, in_ready, out_valid, out_ready, busy;
    logic [31:0] in_l, in_r, p_data, out_l, out_r;
    logic [4:0]  p_addr;
    logic [7:0]  s_addr0, s_addr1, s_addr2, s_addr3;
    logic [31:0] s_data0, s_data1, s_data2, s_data3;

    logic [31:0] p_mem [32];
    logic [31:0] sb0 [256];
    logic [31:0] sb1 [256];
    logic [31:0] sb2 [256];
    logic [31:0] sb3 [256];

    int total = 0;
    int bad   = 0;

    blowfish_round_ctrl #(.ROUNDS(ROUNDS), .PADDR_W(5)) dut (
        .clk(clk), .reset_l(reset_l),
        .in_valid(in_valid), .in_ready(in_ready), .in_l(in_l), .in_r(in_r),
        .p_addr(p_addr), .p_data(p_data),
        .s_addr0(s_addr0), .s_addr1(s_addr1), .s_addr2(s_addr2), .s_addr3(s_addr3),
        .s_data0(s_data0), .s_data1(s_data1), .s_data2(s_data2), .s_data3(s_data3),
        .out_valid(out_valid), .out_ready(out_ready), .out_l(out_l), .out_r(out_r),
        .busy(busy)
    );

    always #5 clk = ~clk;

    assign p_data = p_mem[p_addr];

    always @(posedge clk) begin
        s_data0 <= sb0[s_addr0];
        s_data1 <= sb1[s_addr1];
        s_data2 <= sb2[s_addr2];
        s_data3 <= sb3[s_addr3];
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] ff(input logic [31:0] x);
        return ((sb0[x[31:24]] + sb1[x[23:16]]) ^ sb2[x[15:8]]) + sb3[x[7:0]];
    endfunction

    // Textbook Blowfish encryption over the current tables.
    function automatic logic [63:0] bf_enc(input logic [31:0] l0, input logic [31:0] r0);
        logic [31:0] l, r, tmp;
        l = l0;
        r = r0;
        for (int i = 0; i < ROUNDS; i++) begin
            l   = l ^ p_mem[5'(i)];
            r   = r ^ ff(l);
            tmp = l; l = r; r = tmp;
        end
        tmp = l; l = r; r = tmp;
        r = r ^ p_mem[5'(ROUNDS)];
        l = l ^ p_mem[5'(ROUNDS + 1)];
        return {l, r};
    endfunction

    task automatic fill_tables(input int mode);
        for (int i = 0; i < 32; i++) p_mem[i] = (mode == 2) ? $urandom : 32'h0;
        for (int i = 0; i < 256; i++) begin
            sb0[i] = (mode == 2) ? $urandom : 32'h0;
            sb1[i] = (mode == 2) ? $urandom : 32'h0;
            sb2[i] = (mode == 2) ? $urandom : 32'h0;
            sb3[i] = (mode == 2) ? $urandom : 32'h0;
        end
        if (mode == 1) begin
            p_mem[16] = 32'hFFFFFFFF;
            p_mem[17] = 32'h0000FFFF;
        end
    endtask

    // Entered #1 after an edge with the DUT idle; leaves #1 after the output handshake edge.
    task automatic run_block(input logic [31:0] l, input logic [31:0] r, input logic [63:0] expv,
                             input int hold, input bit keep);
        logic [31:0] lm, rm, t, f;
        in_valid = 1'b1;
        in_l = l;
        in_r = r;
        lm = l;
        rm = r;
        @(posedge clk); #1;
        if (!keep) in_valid = 1'b0;
        in_l = $urandom;
        in_r = $urandom;
        for (int j = 0; j < 2 * ROUNDS + 2; j++) begin
            check("busy_run", 64'(busy), 64'd1);
            check("in_ready_run", 64'(in_ready), 64'd0);
            check("out_valid_run", 64'(out_valid), 64'd0);
            if (j < 2 * ROUNDS && j % 2 == 0) begin
                t = lm ^ p_mem[5'(j / 2)];
                check("p_addr_rnd", 64'(p_addr), 64'(j / 2));
                check("s_addr_rnd", 64'({s_addr0, s_addr1, s_addr2, s_addr3}), 64'(t));
                f = ff(t);
                lm = rm ^ f;
                rm = t;
            end else if (j < 2 * ROUNDS) begin
                check("p_addr_rndb", 64'(p_addr), 64'd0);
                check("s_addr_rndb", 64'({s_addr0, s_addr1, s_addr2, s_addr3}), 64'd0);
            end else begin
                check("p_addr_fin", 64'(p_addr), 64'(j / 2 + ROUNDS / 2 * 0 + (j - 2 * ROUNDS) + ROUNDS - j / 2));
            end
            out_ready = 1'($urandom_range(0, 1));
            @(posedge clk); #1;
        end
        check("out_valid", 64'(out_valid), 64'd1);
        check("out_data", {out_l, out_r}, expv);
        check("p_addr_done", 64'(p_addr), 64'd0);
        out_ready = 1'b0;
        for (int h = 0; h < hold; h++) begin
            @(posedge clk); #1;
            check("hold_valid", 64'(out_valid), 64'd1);
            check("hold_data", {out_l, out_r}, expv);
            check("hold_in_ready", 64'(in_ready), 64'd0);
            check("hold_busy", 64'(busy), 64'd1);
        end
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        check("hs_valid", 64'(out_valid), 64'd0);
        check("hs_in_ready", 64'(in_ready), 64'd1);
        check("hs_busy", 64'(busy), 64'd0);
    endtask

    initial begin
        logic [31:0] a, b;
        reset_l   = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        in_l      = 32'h0;
        in_r      = 32'h0;
        fill_tables(0);
        repeat (2) @(posedge clk);
        #1;
        check("rst_out_valid", 64'(out_valid), 64'd0);
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_in_ready", 64'(in_ready), 64'd1);
        check("rst_p_addr", 64'(p_addr), 64'd0);
        check("rst_s_addr", 64'({s_addr0, s_addr1, s_addr2, s_addr3}), 64'd0);
        check("rst_out", {out_l, out_r}, 64'd0);
        reset_l = 1'b1;
        @(posedge clk); #1;

        run_block(32'h01234567, 32'h89ABCDEF, 64'h89ABCDEF_01234567, 0, 1'b0);

        fill_tables(1);
        run_block(32'h01234567, 32'h89ABCDEF, 64'h89AB3210_FEDCBA98, 5, 1'b0);

        fill_tables(2);
        for (int n = 0; n < 6; n++) begin
            a = $urandom;
            b = $urandom;
            run_block(a, b, bf_enc(a, b), $urandom_range(0, 3), 1'b0);
        end

        // Abort in the middle of round 7's second cycle.
        a = $urandom;
        b = $urandom;
        in_valid = 1'b1;
        in_l = a;
        in_r = b;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (15) @(posedge clk);
        #1;
        check("pre_rst_busy", 64'(busy), 64'd1);
        check("pre_rst_p_addr", 64'(p_addr), 64'd0);
        reset_l = 1'b0;
        #1;
        check("abort_out_valid", 64'(out_valid), 64'd0);
        check("abort_busy", 64'(busy), 64'd0);
        check("abort_in_ready", 64'(in_ready), 64'd1);
        @(posedge clk); #1;
        reset_l = 1'b1;
        @(posedge clk); #1;
        check("post_rst_idle", 64'(in_ready), 64'd1);
        check("post_rst_out_valid", 64'(out_valid), 64'd0);
        a = $urandom;
        b = $urandom;
        run_block(a, b, bf_enc(a, b), 1, 1'b0);

        // Back-to-back blocks with in_valid held high throughout.
        a = $urandom;
        b = $urandom;
        run_block(a, b, bf_enc(a, b), 0, 1'b1);
        a = $urandom;
        b = $urandom;
        run_block(a, b, bf_enc(a, b), 2, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
